qam_tx_sequencer: RTL and testbench



---
 rtl/qam_pkg.sv | 15 +
 rtl/qam_rate_div.sv | 32 +++
 rtl/qam_tx_sequencer.sv | 156 +++++++++++++++
 tb/tb_qam_tx_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared state encoding and symbol constants for the QAM transmit sequencer.
package qam_pkg;

    localparam int SYM_BITS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [SYM_BITS_DEF-1:0] ZERO_SYM = '0;

endpackage

// File: rtl/qam_rate_div.sv
// Prescale counter: counts 0..period while run is high and flags the terminal count.
module qam_rate_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: defaults are assigned first so every path drives cnt_d and no latch is inferred.
    always_comb begin
        tick  = run && (cnt_q == period);
        cnt_d = cnt_q + 1'b1;
        if (!run || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qam_tx_sequencer.sv
// Sample/symbol scheduler for the QAM transmit path: rate strobes, upstream
// symbol fetch over valid/ready, and symbol presentation to the mapper.
module qam_tx_sequencer
    import qam_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int SPS_W      = 4,
    parameter int SYM_BITS   = SYM_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [SPS_W-1:0]      sps,
    input  logic                  data_valid,
    input  logic [SYM_BITS-1:0]   data_in,
    output logic                  data_ready,
    output logic                  sample_en,
    output logic                  sym_load,
    output logic [SYM_BITS-1:0]   sym_out,
    output logic                  busy,
    output logic                  underrun
);

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] lat_pre_q, lat_pre_d;
    logic [SPS_W-1:0]      lat_sps_q, lat_sps_d;
    logic [SPS_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [SYM_BITS-1:0]   hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [SYM_BITS-1:0]   sym_out_q, sym_out_d;
    logic                  underrun_q, underrun_d;
    logic                  active;

    // The prescaler only runs while samples are being produced.
    assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    qam_rate_div #(
        .W (PRESCALE_W)
    ) u_rate_div (
        .clk    (clk),
        .rst    (rst),
        .run    (active),
        .period (lat_pre_q),
        .tick   (sample_en)
    );

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (!active) begin
            sample_cnt_d = '0;
        end else if (sample_en) begin
            sample_cnt_d = (sample_cnt_q == lat_sps_q) ? '0 : sample_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop in RUN looks at the post-update sample count so a boundary exits directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && !stop) state_d = ST_PRIME;
            ST_PRIME: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (data_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:   if (stop) state_d = (sample_cnt_d == '0) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (sample_en && (sample_cnt_q == lat_sps_q)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_ready = 1'b0;
        sym_load   = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_PRIME: data_ready = 1'b1;
            ST_RUN: begin
                data_ready = !hold_valid_q;
                sym_load   = sample_en && (sample_cnt_q == '0);
            end
            default: ;
        endcase
    end

    assign sym_out  = sym_out_q;
    assign underrun = underrun_q;

    always_comb begin
        lat_pre_d    = lat_pre_q;
        lat_sps_d    = lat_sps_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sym_out_d    = sym_out_q;
        underrun_d   = underrun_q;

        if ((state_q == ST_IDLE) && (state_d == ST_PRIME)) begin
            lat_pre_d  = prescale;
            lat_sps_d  = sps;
            underrun_d = 1'b0;
        end

        // A stop in PRIME abandons the fetch, so nothing is captured that cycle.
        if (data_ready && data_valid && !((state_q == ST_PRIME) && stop)) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end

        if (sym_load) begin
            if (hold_valid_q) begin
                sym_out_d    = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                sym_out_d  = SYM_BITS'(ZERO_SYM);
                underrun_d = 1'b1;
            end
        end

        if ((state_q == ST_DRAIN) || (state_d == ST_IDLE)) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_pre_q    <= '0;
            lat_sps_q    <= '0;
            sample_cnt_q <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sym_out_q    <= '0;
            underrun_q   <= 1'b0;
        end else begin
            lat_pre_q    <= lat_pre_d;
            lat_sps_q    <= lat_sps_d;
            sample_cnt_q <= sample_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sym_out_q    <= sym_out_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_qam_tx_sequencer.sv
// Self-checking bench for qam_tx_sequencer: per-cycle vector tables plus a
// symbol scoreboard and hand-written drain/reset sequences.
module tb_qam_tx_sequencer;

    localparam int PW = 16;
    localparam int SW = 4;
    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [SW-1:0] sps = '0;
    logic          data_valid = 1'b0;
    logic [SB-1:0] data_in = '0;
    logic          data_ready;
    logic          sample_en;
    logic          sym_load;
    logic [SB-1:0] sym_out;
    logic          busy;
    logic          underrun;

    qam_tx_sequencer #(
        .PRESCALE_W (PW),
        .SPS_W      (SW),
        .SYM_BITS   (SB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .prescale   (prescale),
        .sps        (sps),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (data_ready),
        .sample_en  (sample_en),
        .sym_load   (sym_load),
        .sym_out    (sym_out),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          start;
        logic          stop;
        logic          dv;
        logic [SB-1:0] din;
        logic          ready;
        logic          sen;
        logic          sload;
        logic          busy;
        logic          und;
        logic [SB-1:0] sym;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic dv, input logic [SB-1:0] din,
                                input logic rdy, input logic se, input logic sl, input logic bs,
                                input logic un, input logic [SB-1:0] sym);
        vec_t v;
        v.start = st;  v.stop = sp;  v.dv = dv;    v.din = din;
        v.ready = rdy; v.sen = se;   v.sload = sl; v.busy = bs;
        v.und = un;    v.sym = sym;
        return v;
    endfunction

    // One row per clock: inputs driven just after the edge, outputs checked mid-cycle.
    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            start      = tbl[i].start;
            stop       = tbl[i].stop;
            data_valid = tbl[i].dv;
            data_in    = tbl[i].din;
            @(negedge clk);
            check($sformatf("%s[%0d].ready", tag, i), data_ready, tbl[i].ready);
            check($sformatf("%s[%0d].sample_en", tag, i), sample_en, tbl[i].sen);
            check($sformatf("%s[%0d].sym_load", tag, i), sym_load, tbl[i].sload);
            check($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].busy);
            check($sformatf("%s[%0d].underrun", tag, i), underrun, tbl[i].und);
            check($sformatf("%s[%0d].sym_out", tag, i), sym_out, tbl[i].sym);
        end
        tbl.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ready"}, data_ready, 0);
        check({tag, ".sample_en"}, sample_en, 0);
        check({tag, ".sym_load"}, sym_load, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".underrun"}, underrun, 0);
        check({tag, ".sym_out"}, sym_out, 0);
    endtask

    logic [SB-1:0] sb_q[$];
    logic [SB-1:0] exp_sym;
    logic          load_pending;
    logic          advance;
    int            drain_sen;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // prescale=3, sps=3, continuous data; prescale rewritten mid-run; stop at sample_cnt=1
        prescale     = 16'd3;
        sps          = 4'd3;
        data_valid   = 1'b1;
        data_in      = 4'h1;
        load_pending = 1'b0;
        advance      = 1'b0;
        drain_sen    = 0;
        for (int c = 0; c <= 50; c++) begin
            @(posedge clk); #1;
            if (advance) data_in = data_in + 1'b1;
            advance = 1'b0;
            start   = (c == 0);
            stop    = (c == 41);
            if (c == 10) prescale = 16'd7;
            @(negedge clk);
            if (load_pending) begin
                check($sformatf("t1.sym_out@%0d", c), sym_out, exp_sym);
                load_pending = 1'b0;
            end
            check($sformatf("t1.sample_en@%0d", c), sample_en, (c >= 5 && c <= 49 && (c - 5) % 4 == 0));
            check($sformatf("t1.sym_load@%0d", c), sym_load, (c == 5 || c == 21 || c == 37));
            check($sformatf("t1.busy@%0d", c), busy, (c >= 1 && c <= 49));
            check($sformatf("t1.ready@%0d", c), data_ready, (c == 1 || c == 6 || c == 22 || c == 38));
            if (c >= 42 && sample_en) drain_sen++;
            if (data_valid && data_ready) begin
                sb_q.push_back(data_in);
                advance = 1'b1;
            end
            if (sym_load) begin
                check($sformatf("t1.sb_depth@%0d", c), sb_q.size(), 1);
                if (sb_q.size() != 0) begin
                    exp_sym      = sb_q.pop_front();
                    load_pending = 1'b1;
                end
            end
        end
        check("t1.drain_sample_en", drain_sen, 2);
        check("t1.sym_out_held", sym_out, 4'h3);
        check("t1.underrun", underrun, 0);
        sb_q.delete();

        // The prescale written during the last run takes effect only now: first strobe at 2+7
        sps     = 4'd0;
        data_in = 4'h9;
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            stop  = 1'b0;
            @(negedge clk);
            check($sformatf("t6.sample_en@%0d", c), sample_en, (c == 9));
            check($sformatf("t6.sym_load@%0d", c), sym_load, (c == 9));
            check($sformatf("t6.ready@%0d", c), data_ready, (c == 1 || c == 10));
        end
        check("t6.sym_out", sym_out, 4'h9);

        // Asynchronous reset in RUN while data_ready is high
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid_run");
        @(posedge clk); #1;
        rst        = 1'b1;
        data_valid = 1'b0;

        // prescale=0, sps=0: every RUN cycle is a symbol boundary; hold refills every other cycle
        prescale = 16'd0;
        sps      = 4'd0;
        tbl.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk(0, 0, 1, 4'h5, 1, 0, 0, 1, 0, 4'h0));
        tbl.push_back(mk(0, 0, 1, 4'h6, 0, 1, 1, 1, 0, 4'h0));
        tbl.push_back(mk(0, 0, 1, 4'h7, 1, 1, 1, 1, 0, 4'h5));
        tbl.push_back(mk(0, 0, 1, 4'h8, 0, 1, 1, 1, 1, 4'h0));
        tbl.push_back(mk(0, 0, 1, 4'h8, 1, 1, 1, 1, 1, 4'h7));
        tbl.push_back(mk(0, 0, 1, 4'h9, 0, 1, 1, 1, 1, 4'h0));
        tbl.push_back(mk(0, 1, 0, 4'h9, 1, 1, 1, 1, 1, 4'h8));
        tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 4'h0));
        run_table("t2");

        // prescale=1, sps=1: underrun after one symbol, stop -> DRAIN, restart, stop in PRIME, start+stop
        prescale = 16'd1;
        sps      = 4'd1;
        tbl.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 0, 1, 4'hC, 1, 0, 0, 1, 0, 4'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 4'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 0, 1, 1, 1, 0, 4'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 0, 1, 0, 4'hC));
        tbl.push_back(mk(0, 0, 0, 4'h0, 1, 1, 0, 1, 0, 4'hC));
        tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 0, 1, 0, 4'hC));
        tbl.push_back(mk(0, 0, 0, 4'h0, 1, 1, 1, 1, 0, 4'hC));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 1, 1, 4'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 0, 1, 0, 1, 1, 4'h0));
        tbl.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 1, 0, 4'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 4'h0));
        run_table("t3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
